// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the fetch-side branch predictor.
package branch_predictor_pkg;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_e;

    // Saturating counter encodings; bit 1 is the taken prediction.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-value logic used on every table update.
module bp_sat_ctr
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] next
);

    always_comb begin
        next = ctr;
        if (inc) begin
            if (ctr != ST) next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor with registered mispredict redirect and squash window.
// Optional BP_STATS_EN adds branch / mispredict event counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W      = 6,
    parameter int XLEN       = 32,
    parameter int SQUASH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc_in,
    output logic            pred_taken_out,
    output logic [XLEN-1:0] pred_target_out,
    input  logic            ex_valid_in,
    input  logic [XLEN-1:0] ex_pc_in,
    input  logic            ex_enable_in,
    input  logic            ex_jalr_in,
    input  logic            ex_taken_in,
    input  logic [XLEN-1:0] ex_target_in,
    input  logic            ex_pred_taken_in,
    input  logic [XLEN-1:0] ex_pred_target_in,
    output logic            mispredict_out,
    output logic [XLEN-1:0] redirect_pc_out,
    output logic            flush_out,
`ifdef BP_STATS_EN
    output logic [31:0]     stat_branches_out,
    output logic [31:0]     stat_mispred_out,
`endif
    output state_e          dbg_state
);

    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam int CNT_W = (SQUASH_CYC > 1) ? $clog2(SQUASH_CYC) : 1;

    logic             valid_q  [N];
    logic [TAG_W-1:0] tag_q    [N];
    logic [XLEN-1:0]  target_q [N];
    logic [1:0]       ctr_q    [N];

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic             upd, taken_eff, mispred;
    logic [1:0]       ctr_nxt;

    assign f_idx = fetch_pc_in[IDX_W+1:2];
    assign f_tag = fetch_pc_in[XLEN-1:IDX_W+2];
    assign e_idx = ex_pc_in[IDX_W+1:2];
    assign e_tag = ex_pc_in[XLEN-1:IDX_W+2];

    // Fetch reads the registered table, so a same-cycle write is not visible.
    assign f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken_out  = f_hit && ctr_q[f_idx][1];
    assign pred_target_out = pred_taken_out ? target_q[f_idx] : fetch_pc_in + XLEN'(4);

    assign e_hit     = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign upd       = ex_valid_in && (ex_enable_in || ex_jalr_in) && (state_q == RUN);
    assign taken_eff = ex_taken_in || ex_jalr_in;
    assign mispred   = upd && ((taken_eff != ex_pred_taken_in) ||
                               (taken_eff && ex_pred_taken_in && (ex_target_in != ex_pred_target_in)));
    assign dbg_state = state_q;

    bp_sat_ctr u_sat (
        .ctr  (ctr_q[e_idx]),
        .inc  (ex_taken_in),
        .next (ctr_nxt)
    );

    // Taken outcomes allocate/overwrite; a not-taken miss leaves the table alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (upd) begin
            if (ex_jalr_in) begin
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= ex_target_in;
                ctr_q[e_idx]    <= ST;
            end else if (ex_taken_in) begin
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= ex_target_in;
                ctr_q[e_idx]    <= ctr_nxt;
            end else if (e_hit) begin
                ctr_q[e_idx]    <= ctr_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            cnt_q           <= '0;
            mispredict_out  <= 1'b0;
            redirect_pc_out <= '0;
            flush_out       <= 1'b0;
        end else begin
            mispredict_out <= 1'b0;
            case (state_q)
                RUN: begin
                    if (mispred) begin
                        state_q         <= SQUASH;
                        cnt_q           <= CNT_W'(SQUASH_CYC - 1);
                        mispredict_out  <= 1'b1;
                        flush_out       <= 1'b1;
                        redirect_pc_out <= taken_eff ? ex_target_in : ex_pc_in + XLEN'(4);
                    end
                end
                SQUASH: begin
                    if (cnt_q == '0) begin
                        state_q   <= RUN;
                        flush_out <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_out <= '0;
            stat_mispred_out  <= '0;
        end else begin
            if (upd)     stat_branches_out <= stat_branches_out + 32'd1;
            if (mispred) stat_mispred_out  <= stat_mispred_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor: training, redirects, squash window, reset.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetch_pc = 32'h0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic        ex_enable = 1'b0;
    logic        ex_jalr = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = 32'h0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        flush;
    state_e      dbg_state;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int n_vec = 0;
    int n_err = 0;

    branch_predictor dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_pc_in       (fetch_pc),
        .pred_taken_out    (pred_taken),
        .pred_target_out   (pred_target),
        .ex_valid_in       (ex_valid),
        .ex_pc_in          (ex_pc),
        .ex_enable_in      (ex_enable),
        .ex_jalr_in        (ex_jalr),
        .ex_taken_in       (ex_taken),
        .ex_target_in      (ex_target),
        .ex_pred_taken_in  (ex_pred_taken),
        .ex_pred_target_in (ex_pred_target),
        .mispredict_out    (mispredict),
        .redirect_pc_out   (redirect_pc),
        .flush_out         (flush),
`ifdef BP_STATS_EN
        .stat_branches_out (stat_branches),
        .stat_mispred_out  (stat_mispred),
`endif
        .dbg_state         (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fetch_check(input string tag, input logic [31:0] pc,
                               input logic exp_taken, input logic [31:0] exp_tgt);
        fetch_pc = pc;
        #1;
        check({tag, "_taken"}, {31'h0, pred_taken}, {31'h0, exp_taken});
        check({tag, "_target"}, pred_target, exp_tgt);
    endtask

    // Presents one execute-stage instruction for one clock edge.
    task automatic exec_op(input logic [31:0] pc, input logic en, input logic jalr,
                           input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_enable      = en;
        ex_jalr        = jalr;
        ex_taken       = taken;
        ex_target      = tgt;
        ex_pred_taken  = ptaken;
        ex_pred_target = ptgt;
        @(posedge clk);
        #1;
        ex_valid  = 1'b0;
        ex_enable = 1'b0;
        ex_jalr   = 1'b0;
        ex_taken  = 1'b0;
    endtask

    task automatic check_redirect(input string tag, input logic exp_mp, input logic [31:0] exp_pc);
        check({tag, "_mispredict"}, {31'h0, mispredict}, {31'h0, exp_mp});
        if (exp_mp) begin
            check({tag, "_redirect"}, redirect_pc, exp_pc);
            check({tag, "_flush"}, {31'h0, flush}, 32'h1);
        end else begin
            check({tag, "_noflush"}, {31'h0, flush}, 32'h0);
        end
    endtask

    initial begin
        // reset state
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);
        fetch_check("rst_fetch", 32'h100, 1'b0, 32'h104);
        check("rst_mispredict", {31'h0, mispredict}, 32'h0);
        check("rst_redirect", redirect_pc, 32'h0);
        check("rst_flush", {31'h0, flush}, 32'h0);
        check("rst_state", {31'h0, dbg_state}, {31'h0, RUN});

        // train 0x100 -> 0x80 twice, each predicted not-taken
        exec_op(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        check_redirect("train1", 1'b1, 32'h80);
        check("train1_state", {31'h0, dbg_state}, {31'h0, SQUASH});
        wait_cycles(1);
        check("train1_pulse_end", {31'h0, mispredict}, 32'h0);
        check("train1_flush_hold", {31'h0, flush}, 32'h1);
        wait_cycles(1);
        check("train1_flush_end", {31'h0, flush}, 32'h0);
        exec_op(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        check_redirect("train2", 1'b1, 32'h80);
        wait_cycles(2);
        fetch_check("trained", 32'h100, 1'b1, 32'h80);

        // ctr 11 -> 10 -> 01 with not-taken outcomes, then back up
        exec_op(32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        check_redirect("nt1", 1'b1, 32'h104);
        wait_cycles(2);
        fetch_check("nt1_pred", 32'h100, 1'b1, 32'h80);
        exec_op(32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        check_redirect("nt2", 1'b1, 32'h104);
        wait_cycles(2);
        fetch_check("nt2_pred", 32'h100, 1'b0, 32'h104);
        exec_op(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        check_redirect("t3", 1'b1, 32'h80);
        wait_cycles(2);
        exec_op(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        check_redirect("t4_correct", 1'b0, 32'h0);
        wait_cycles(1);

        // jalr target mismatch; 0x200 shares an index with 0x100
        exec_op(32'h200, 1'b0, 1'b1, 1'b0, 32'h400, 1'b1, 32'h300);
        check_redirect("jalr", 1'b1, 32'h400);
        wait_cycles(2);
        fetch_check("jalr_pred", 32'h200, 1'b1, 32'h400);
        fetch_check("collide_pred", 32'h100, 1'b0, 32'h104);

        // branch arriving during the squash window is ignored
        wait_cycles(1);
        exec_op(32'h10c, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h110);
        check_redirect("sq_trigger", 1'b1, 32'h20);
        exec_op(32'h140, 1'b1, 1'b0, 1'b1, 32'h60, 1'b0, 32'h144);
        check("sq_ignored_pulse", {31'h0, mispredict}, 32'h0);
        check("sq_flush_hold", {31'h0, flush}, 32'h1);
        wait_cycles(1);
        check("sq_flush_end", {31'h0, flush}, 32'h0);
        check("sq_ignored_late", {31'h0, mispredict}, 32'h0);
        check("sq_state_run", {31'h0, dbg_state}, {31'h0, RUN});
        fetch_check("sq_not_trained", 32'h140, 1'b0, 32'h144);
        fetch_check("sq_trigger_trained", 32'h10c, 1'b1, 32'h20);

        // reset asserted mid-squash
        wait_cycles(1);
        exec_op(32'h300, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h304);
        check_redirect("pre_rst", 1'b1, 32'h500);
        rst = 1'b1;
        #1;
        check("async_flush", {31'h0, flush}, 32'h0);
        check("async_mispredict", {31'h0, mispredict}, 32'h0);
        check("async_redirect", redirect_pc, 32'h0);
        check("async_state", {31'h0, dbg_state}, {31'h0, RUN});
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(1);
        fetch_check("clr_200", 32'h200, 1'b0, 32'h204);
        fetch_check("clr_10c", 32'h10c, 1'b0, 32'h110);
        fetch_check("clr_300", 32'h300, 1'b0, 32'h304);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor and PC-redirect stage, directly downstream of branch_unit.
- Gives fetch a next-PC prediction from a direct-mapped BTB with 2-bit saturating counters.
- Takes the resolved branch/jalr outcome (branch_out, enable, jal_enab) back from execute, trains the table, and raises a registered mispredict redirect plus a wrong-path squash window.

Parameters:
IDX_W, 6, BTB index width (2^IDX_W entries, indexed by pc[IDX_W+1:2])
XLEN, 32, address width
SQUASH_CYC, 2, cycles flush_out stays high after a mispredict (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
fetch_pc_in  in  XLEN  PC being fetched
pred_taken_out  out  1  prediction: redirect fetch to pred_target_out
pred_target_out  out  XLEN  predicted target (fetch_pc_in+4 when not taken)
ex_valid_in  in  1  execute-stage instruction valid this cycle
ex_pc_in  in  XLEN  PC of execute-stage instruction
ex_enable_in  in  1  conditional branch (branch_unit enable)
ex_jalr_in  in  1  jalr (branch_unit jal_enab)
ex_taken_in  in  1  actual outcome (branch_unit branch_out)
ex_target_in  in  XLEN  resolved taken target
ex_pred_taken_in  in  1  prediction carried down the pipe for this instruction
ex_pred_target_in  in  XLEN  predicted target carried down the pipe
mispredict_out  out  1  one-cycle redirect pulse
redirect_pc_out  out  XLEN  correct PC, valid while mispredict_out=1
flush_out  out  1  squash younger wrong-path instructions

Behaviour:
- Entry: valid(1), tag(pc[XLEN-1:IDX_W+2]), target(XLEN), ctr(2). Reset: all valid=0, ctr=2'b01 (weakly not-taken).
- Predict (combinational): hit = valid && tag match. pred_taken_out = hit && ctr[1]. pred_target_out = entry target if pred_taken_out, else fetch_pc_in+4 (mod 2^XLEN).
- Update qualifier: upd = ex_valid_in && (ex_enable_in || ex_jalr_in) && state==RUN. Table write happens on the clock edge.
- Conditional branch: taken -> ctr saturating +1 (max 11). Not taken -> saturating -1 (min 00). Taken also writes tag, target, valid=1. Not taken on a miss: no allocation.
- jalr: always taken. Allocate/overwrite with ctr=2'b11.
- Effective actual: taken_eff = ex_taken_in || ex_jalr_in.
- Mispredict when upd and either:
  - taken_eff != ex_pred_taken_in, or
  - taken_eff && ex_pred_taken_in && ex_target_in != ex_pred_target_in.
- Mispredict response, registered (1-cycle latency): mispredict_out=1 for one cycle. redirect_pc_out = ex_target_in if taken_eff, else ex_pc_in+4.
- FSM:
  - RUN: mispredict -> SQUASH; counter loads SQUASH_CYC-1; flush_out asserts with mispredict_out.
  - SQUASH: flush_out=1; ex_valid_in ignored (no table writes, no new mispredict); counter decrements; 0 -> RUN.
- Same-index read and write in one cycle: fetch sees the old entry (no bypass).
- Index/tag collision: the write overwrites the entry (no replacement policy).
- Reset values: pred_taken_out=0 (table empty), mispredict_out=0, redirect_pc_out=0, flush_out=0, state=RUN.
- rst asserted mid-squash: state returns to RUN immediately and the table clears.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs stat_branches_out[31:0] and stat_mispred_out[31:0]. Each is a wrapping counter that increments on upd and on mispredict respectively, cleared by rst.
- Undefined: the ports and counters are absent. Behaviour otherwise identical.

Decomposition:
- Shared package:
  - opcode constants OPC_BRANCH=5'b11000, OPC_JALR=5'b11001, OPC_JAL=5'b11011
  - FSM state typedef {RUN, SQUASH}
  - counter encodings SNT=00, WNT=01, WT=10, ST=11
- One sub-module, bp_sat_ctr: 2-bit saturating next-value function/module, reused for each update.

Test Plan:
- After rst, fetch_pc_in=0x100 -> pred_taken_out=0, pred_target_out=0x104.
- Branch at 0x100 taken twice to 0x80, both predicted not-taken:
  - two mispredict pulses, redirect_pc_out=0x80.
  - then fetch 0x100 -> pred_taken_out=1, pred_target_out=0x80.
- Entry ctr=11, then branch resolved not-taken with ex_pred_taken_in=1:
  - mispredict_out=1, redirect_pc_out=0x104, ctr->10, prediction still taken.
- jalr at 0x200 to 0x400, predicted taken to 0x300:
  - target-mismatch mispredict, redirect_pc_out=0x400.
  - entry target updated to 0x400.
- Mispredict, then ex_valid_in with a branch in the next cycle:
  - flush_out high for 2 cycles; that branch neither updates the table nor pulses mispredict_out.
- rst pulse during SQUASH -> flush_out=0 asynchronously; all previously trained PCs predict not-taken.
